// File: rtl/seg7_pkg.sv
// ============================================================================
// Module      : seg7_pkg
// Description : Shared constants and helpers for the 4-digit 7-segment
//               scan multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

    localparam logic [6:0] SEG_BLANK   = 7'b1111111;
    localparam logic [3:0] AN_OFF      = 4'b1111;
    localparam int         NUM_DIGITS  = 4;
    localparam int         DIGIT_IDX_W = 2;

    // Active-low one-hot anode pattern for a digit index
    function automatic logic [3:0] an_onehot_low(input logic [DIGIT_IDX_W-1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_scan_mux_hex7seg.sv
// ============================================================================
// Module      : hexTo7Segment
// Description : Nibble to active-low 7-segment decoder, seg[0]=a .. seg[6]=g.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hexTo7Segment (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Pure lookup of the lit-segment pattern for each hex glyph
    always_comb begin
        seg = 7'b1111111;
        case (hex)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_mux.sv
// ============================================================================
// Module      : seg7_scan_mux
// Description : Time-multiplexes a 16-bit hex value onto a 4-digit
//               common-anode 7-segment display. A shadow register is copied
//               to the display register only at frame boundaries so a new
//               result never shows up half-drawn.
//               Optional macro SEG7_LEADING_ZERO_BLANK_EN suppresses leading
//               zero digits (digit 0 is always shown).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int DIV_COUNT = 100000,
    parameter int CNT_W     = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  dp_in,
    input  logic        blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    logic [CNT_W-1:0]       r_div_cnt;
    logic [DIGIT_IDX_W-1:0] r_digit_idx;
    logic [15:0]            r_shadow;
    logic [15:0]            r_disp;

    logic                   w_tick;
    logic                   w_frame;
    logic [3:0]             w_nibble;
    logic [6:0]             w_dec_seg;
    logic [3:0]             w_an_nxt;
    logic [6:0]             w_seg_nxt;
    logic                   w_dp_nxt;

    assign w_tick  = (r_div_cnt == CNT_W'(DIV_COUNT - 1));
    assign w_frame = w_tick && (r_digit_idx == DIGIT_IDX_W'(NUM_DIGITS - 1));

    // Slot divider and the 4-state digit ring it advances
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt   <= '0;
            r_digit_idx <= '0;
        end else if (w_tick) begin
            r_div_cnt   <= '0;
            r_digit_idx <= r_digit_idx + 1'b1;
        end else begin
            r_div_cnt   <= r_div_cnt + 1'b1;
        end
    end

    // Shadow capture on load; display copy at frame boundary, a coincident load wins
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow <= '0;
            r_disp   <= '0;
        end else begin
            if (load)
                r_shadow <= value;
            if (w_frame)
                r_disp <= load ? value : r_shadow;
        end
    end

    assign w_nibble = r_disp[{r_digit_idx, 2'b00} +: 4];

    hexTo7Segment u_dec (
        .hex (w_nibble),
        .seg (w_dec_seg)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Bit k set when digit k and every digit above it are zero
    logic [3:0] w_upper_zero;
    logic       w_suppress;

    assign w_upper_zero[3] = (r_disp[15:12] == 4'h0);
    assign w_upper_zero[2] = (r_disp[15:8]  == 8'h00);
    assign w_upper_zero[1] = (r_disp[15:4]  == 12'h000);
    assign w_upper_zero[0] = 1'b0;
    assign w_suppress      = w_upper_zero[r_digit_idx];
`endif

    // Next-state values for the pin registers
    always_comb begin
        w_an_nxt  = an_onehot_low(r_digit_idx);
        w_seg_nxt = w_dec_seg;
        w_dp_nxt  = ~dp_in[r_digit_idx];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        // A suppressed digit stays lit only to show a requested decimal point
        if (w_suppress) begin
            w_seg_nxt = SEG_BLANK;
            if (!dp_in[r_digit_idx])
                w_an_nxt = AN_OFF;
        end
`endif
        if (blank)
            w_an_nxt = AN_OFF;
    end

    // Registered pin outputs, one cycle behind the scan state
    always_ff @(posedge clk) begin
        if (reset) begin
            an          <= AN_OFF;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            an          <= w_an_nxt;
            seg         <= w_seg_nxt;
            dp          <= w_dp_nxt;
            frame_start <= w_frame;
        end
    end

endmodule

`default_nettype wire

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
- Time-multiplexes a 16-bit hex value onto the board's 4-digit common-anode 7-segment display.
- Sits directly upstream of the hexTo7Segment nibble decoder. It selects one nibble per scan slot, drives that nibble into the decoder, and registers the anode, segment and dp outputs to the pins.
- A shadow register and frame-aligned update prevent torn digits when the calculator core loads a new result.

Parameters:
- DIV_COUNT, 100000: clk cycles per digit slot (1 kHz per digit at 100 MHz). Legal range ≥2.
- CNT_W, 17: width of the slot divider counter. Must satisfy 2^CNT_W ≥ DIV_COUNT.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- value  in  16  hex value to display; nibble k shown on digit k, digit 0 rightmost.
- load  in  1  single-cycle strobe that captures value into the shadow register.
- dp_in  in  4  per-digit decimal-point request, active-high.
- blank  in  1  forces all anodes off while high.
- an  out  4  anode enables, active-low; an[k] selects digit k.
- seg  out  7  segment cathodes, active-low; seg[0]=a … seg[6]=g, same encoding as hexTo7Segment.
- dp  out  1  decimal-point cathode, active-low.
- frame_start  out  1  one-cycle pulse when digit 0 becomes active.

Behaviour:
- Reset, applied in any state and taking effect on the next edge:
  - div_cnt=0, digit_idx=0, shadow=0, disp=0.
  - an=4'b1111, seg=7'b1111111, dp=1, frame_start=0.
- Divider:
  - div_cnt increments every cycle.
  - At DIV_COUNT-1 it wraps to 0 and asserts an internal tick.
  - On tick, digit_idx advances 0→1→2→3→0.
- Frame boundary: the tick on which digit_idx goes 3→0.
  - On that edge: disp ← shadow, and frame_start=1 for one cycle.
- load:
  - On load, shadow ← value.
  - If load coincides with a frame boundary, both shadow and disp take value that same cycle (load wins).
  - Multiple loads within a frame: only the last one is displayed.
- Output path:
  - Registered; outputs reflect digit_idx and disp with exactly 1 cycle latency.
  - an = one-hot-low of digit_idx.
  - seg = decoder(disp[4*digit_idx +: 4]).
  - dp = ~dp_in[digit_idx].
- First cycle after reset release: outputs still hold their reset values. From the second cycle: an=4'b1110, showing digit 0 of disp=0 (seg=7'b1000000).
- blank=1:
  - The next cycle an=4'b1111.
  - seg and dp are still computed.
  - Divider, digit_idx, shadow and disp keep running, so releasing blank resumes mid-frame with no restart.
- dp_in is sampled live each cycle, not shadowed.
- No other state machine. The digit scan is a 4-state ring; no illegal states are reachable because digit_idx is 2 bits.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit k (k=3,2,1) is blanked if disp nibbles k..3 are all zero.
  - Blanked digit: an bit stays high, unless dp_in[k]=1. In that case the anode is on with seg=7'b1111111 and dp=0.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- Undefined: all four digits are always shown, including leading zeros.

Decomposition:
- Shared package seg7_pkg holds:
  - SEG_BLANK = 7'b1111111
  - AN_OFF = 4'b1111
  - NUM_DIGITS = 4
  - the DIGIT_IDX_W = 2 constant
- Sub-module: one instance of the existing hexTo7Segment decoder on the selected nibble. Its output feeds the seg output register.
- No other sub-modules.

Test Plan (DIV_COUNT=4):
- Reset then idle with value never loaded:
  - Reset → an=1111, seg=1111111, dp=1.
  - After release, an cycles 1110,1101,1011,0111 every 4 clk with seg=1000000.
  - frame_start pulses every 16 clk.
- load with value=16'h1A3F mid-frame → digits unchanged until the next frame_start. Then digit0..3 show seg 0001110, 0110000, 0001000, 1111001.
- Simultaneous load and frame boundary with value=16'h00B2 → disp updates that edge. Digit 0 shows 0100100 in the same frame.
- blank=1 for 10 cycles mid-frame → an=1111 one cycle after assertion. After release, an resumes the correct digit for the current div_cnt/digit_idx with no frame restart.
- dp_in=4'b0100 → dp=0 only while an=1011.
- With SEG7_LEADING_ZERO_BLANK_EN, value=16'h0005:
  - Only an[0] ever goes low.
  - With dp_in=4'b0010, an[1] also goes low with seg=1111111 and dp=0.
  - Reset asserted mid-digit → outputs return to reset values on the next edge.
